// File: rtl/dram_dq_rx_edgelogic.sv
// dram_dq_rx_edgelogic: read-data capture for one DRAM DQ pad slice.
// A capture window opens a programmable number of cycles after a read command.
// In that window the rise/fall pad samples are paired into one word per clock
// and buffered in a 4-entry FIFO, which drains through a valid/ready handshake.
// Optional feature: define DRAM_RX_SCAN_EN to chain latency, burst and state
// registers into a scan path (scan_si -> scan_so).
module dram_dq_rx_edgelogic #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               testmode_l,
   input  logic               rd_cmd_issue,
   input  logic [3:0]         rd_latency,
   input  logic [1:0]         rd_burst,
   input  logic [WIDTH-1:0]   pad_dq_rise,
   input  logic [WIDTH-1:0]   pad_dq_fall,
   output logic [2*WIDTH-1:0] rx_data,
   output logic               rx_valid,
   input  logic               rx_ready,
   output logic               rx_busy,
   output logic               rx_overflow,
   output logic               rd_cmd_err,
   input  logic               scan_si,
   input  logic               scan_se,
   output logic               scan_so
);

   localparam int unsigned DW    = 2 * WIDTH;
   localparam int unsigned DEPTH = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_CAPTURE = 2'd2
   } state_e;

   state_e        state_q, state_n;
   logic [3:0]    lat_q, lat_n;
   logic [1:0]    burst_q, burst_n;
   logic [3:0]    wait_cnt_q, wait_cnt_n;
   logic [1:0]    beat_cnt_q, beat_cnt_n;
   logic [3:0]    eff_lat;
   logic          cmd_ignored;
   logic          capture;
   logic          push;

   logic [DW-1:0] mem [DEPTH];
   logic [1:0]    wr_ptr, rd_ptr, rd_ptr_n;
   logic [2:0]    count, count_n;
   logic [DW-1:0] push_data, head_n;
   logic          pop, full, push_ok, overflow_evt;

   // Next-state logic: command acceptance, wait countdown, beat counting
   always_comb begin
      state_n     = state_q;
      lat_n       = lat_q;
      burst_n     = burst_q;
      wait_cnt_n  = wait_cnt_q;
      beat_cnt_n  = beat_cnt_q;
      cmd_ignored = 1'b0;
      capture     = 1'b0;
      eff_lat     = testmode_l ? rd_latency : 4'd0;
      case (state_q)
         S_IDLE: begin
            if (rd_cmd_issue) begin
               lat_n      = eff_lat;
               burst_n    = rd_burst;
               wait_cnt_n = eff_lat;
               beat_cnt_n = 2'd0;
               state_n    = (eff_lat == 4'd0) ? S_CAPTURE : S_WAIT;
            end
         end
         S_WAIT: begin
            cmd_ignored = rd_cmd_issue;
            wait_cnt_n  = wait_cnt_q - 4'd1;
            if (wait_cnt_q <= 4'd1) begin
               wait_cnt_n = 4'd0;
               beat_cnt_n = 2'd0;
               state_n    = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            capture = 1'b1;
            if (beat_cnt_q == burst_q) begin
               beat_cnt_n = 2'd0;
               if (rd_cmd_issue) begin
                  // back-to-back burst accepted on the final beat
                  lat_n      = eff_lat;
                  burst_n    = rd_burst;
                  wait_cnt_n = eff_lat;
                  state_n    = (eff_lat == 4'd0) ? S_CAPTURE : S_WAIT;
               end else begin
                  state_n = S_IDLE;
               end
            end else begin
               cmd_ignored = rd_cmd_issue;
               beat_cnt_n  = beat_cnt_q + 2'd1;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

`ifdef DRAM_RX_SCAN_EN
   logic [7:0] scan_chain, scan_shift;
   assign scan_chain = {state_q, burst_q, lat_q};
   assign scan_shift = {scan_chain[6:0], scan_si};
   assign scan_so    = scan_chain[7];
   assign push       = capture & ~scan_se;
`else
   // latched latency is only observable through the scan chain
   logic scan_unused;
   assign scan_unused = ^{scan_si, scan_se, lat_q};
   assign scan_so     = 1'b0;
   assign push        = capture;
`endif

   // Control registers: state, latched L/B, counters, busy and command-error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         lat_q      <= 4'd0;
         burst_q    <= 2'd0;
         wait_cnt_q <= 4'd0;
         beat_cnt_q <= 2'd0;
         rx_busy    <= 1'b0;
         rd_cmd_err <= 1'b0;
`ifdef DRAM_RX_SCAN_EN
      end else if (scan_se) begin
         state_q <= state_e'(scan_shift[7:6]);
         burst_q <= scan_shift[5:4];
         lat_q   <= scan_shift[3:0];
         rx_busy <= (scan_shift[7:6] != 2'd0);
`endif
      end else begin
         state_q    <= state_n;
         lat_q      <= lat_n;
         burst_q    <= burst_n;
         wait_cnt_q <= wait_cnt_n;
         beat_cnt_q <= beat_cnt_n;
         rx_busy    <= (state_n != S_IDLE);
         if (cmd_ignored) rd_cmd_err <= 1'b1;
      end
   end

   // FIFO control: push/pop qualification and registered next head entry
   always_comb begin
      push_data    = {pad_dq_fall, pad_dq_rise};
      pop          = rx_valid & rx_ready;
      full         = (count == 3'd4);
      push_ok      = push & (~full | pop);
      overflow_evt = push & full & ~pop;
      rd_ptr_n     = pop ? rd_ptr + 2'd1 : rd_ptr;
      count_n      = count + 3'(push_ok) - 3'(pop);
      head_n       = (push_ok && (wr_ptr == rd_ptr_n)) ? push_data : mem[rd_ptr_n];
   end

   // FIFO pointers, occupancy, registered head and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= 2'd0;
         rd_ptr      <= 2'd0;
         count       <= 3'd0;
         rx_valid    <= 1'b0;
         rx_data     <= '0;
         rx_overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 2'd1;
         rd_ptr   <= rd_ptr_n;
         count    <= count_n;
         rx_valid <= (count_n != 3'd0);
         if (count_n != 3'd0) rx_data <= head_n;
         if (overflow_evt) rx_overflow <= 1'b1;
      end
   end

   // FIFO storage; stale entries are masked by the pointers after reset
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: tb/tb_dram_dq_rx_edgelogic.sv
// Directed bench for dram_dq_rx_edgelogic: per-cycle vector table plus
// latency probes. Inputs driven and outputs sampled on the falling edge.
module tb_dram_dq_rx_edgelogic;

   logic       clk = 1'b0;
   logic       rst;
   logic       testmode_l;
   logic       rd_cmd_issue;
   logic [3:0] rd_latency;
   logic [1:0] rd_burst;
   logic [3:0] pad_dq_rise, pad_dq_fall;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready, rx_busy, rx_overflow, rd_cmd_err;
   logic       scan_si, scan_se, scan_so;

   dram_dq_rx_edgelogic #(.WIDTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .testmode_l   (testmode_l),
      .rd_cmd_issue (rd_cmd_issue),
      .rd_latency   (rd_latency),
      .rd_burst     (rd_burst),
      .pad_dq_rise  (pad_dq_rise),
      .pad_dq_fall  (pad_dq_fall),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rx_busy      (rx_busy),
      .rx_overflow  (rx_overflow),
      .rd_cmd_err   (rd_cmd_err),
      .scan_si      (scan_si),
      .scan_se      (scan_se),
      .scan_so      (scan_so)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, tm, iss;
      logic [3:0] lat;
      logic [1:0] bur;
      logic [7:0] pd;   // {fall, rise}
      logic       rdy;
      logic       ev;
      logic [7:0] ed;
      logic       eb, eo, ee;
   } vec_t;

   vec_t tv[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   function automatic void add(input logic r, input logic tm, input logic iss,
                               input logic [3:0] lat, input logic [1:0] bur,
                               input logic [7:0] pd, input logic rdy,
                               input logic ev, input logic [7:0] ed,
                               input logic eb, input logic eo, input logic ee);
      vec_t v;
      v.rst = r;  v.tm = tm; v.iss = iss; v.lat = lat; v.bur = bur;
      v.pd = pd;  v.rdy = rdy;
      v.ev = ev;  v.ed = ed; v.eb = eb; v.eo = eo; v.ee = ee;
      tv.push_back(v);
   endfunction

   task automatic chk(input int idx, input string nm, input logic [7:0] got, input logic [7:0] want);
      if (got !== want) begin
         n_miss++;
         $display("FAIL vec%0d %s: got %0h want %0h", idx, nm, got, want);
      end
   endtask

   // Issue one command from idle; expect first rx_valid exp_first cycles later
   task automatic probe(input logic [3:0] lat, input logic [1:0] bur, input logic tm, input int exp_first);
      int first;
      int nval;
      first = -1;
      nval  = 0;
      @(negedge clk);
      rd_cmd_issue = 1'b1; rd_latency = lat; rd_burst = bur; testmode_l = tm;
      rx_ready = 1'b1; pad_dq_rise = 4'h3; pad_dq_fall = 4'hC;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         rd_cmd_issue = 1'b0;
         testmode_l   = 1'b1;
         if (rx_valid) begin
            if (first < 0) first = k;
            nval++;
         end
      end
      n_vec++;
      if (first != exp_first) begin
         n_miss++;
         $display("FAIL probe lat%0d tm%0d first_valid: got %0d want %0d", lat, tm, first, exp_first);
      end
      n_vec++;
      if (nval != int'(bur) + 1) begin
         n_miss++;
         $display("FAIL probe lat%0d tm%0d beats: got %0d want %0d", lat, tm, nval, int'(bur) + 1);
      end
   endtask

   initial begin
      rst = 1'b1; testmode_l = 1'b1; rd_cmd_issue = 1'b0; rd_latency = '0; rd_burst = '0;
      pad_dq_rise = '0; pad_dq_fall = '0; rx_ready = 1'b1; scan_si = 1'b0; scan_se = 1'b0;

      // rst tm iss lat bur pd rdy | valid data busy ovf err
      // single burst L=3 B=3, issue at c2
      add(0,1,0,0,0,8'h5A,1, 0,8'h00,0,0,0);
      add(0,1,1,3,3,8'h5A,1, 0,8'h00,0,0,0);
      add(0,1,0,0,0,8'h5A,1, 0,8'h00,1,0,0);
      add(0,1,0,0,0,8'h5A,1, 0,8'h00,1,0,0);
      add(0,1,0,0,0,8'h5A,1, 0,8'h00,1,0,0);
      add(0,1,0,0,0,8'h21,1, 0,8'h00,1,0,0);
      add(0,1,0,0,0,8'h43,1, 1,8'h21,1,0,0);
      add(0,1,0,0,0,8'h65,1, 1,8'h43,1,0,0);
      add(0,1,0,0,0,8'h87,1, 1,8'h65,1,0,0);
      add(0,1,0,0,0,8'h5A,1, 1,8'h87,0,0,0);
      add(0,1,0,0,0,8'h5A,1, 0,8'h87,0,0,0);
      // same burst with testmode_l=0
      add(0,0,1,3,3,8'h5A,1, 0,8'h87,0,0,0);
      add(0,1,0,0,0,8'h21,1, 0,8'h87,1,0,0);
      add(0,1,0,0,0,8'h43,1, 1,8'h21,1,0,0);
      add(0,1,0,0,0,8'h65,1, 1,8'h43,1,0,0);
      add(0,1,0,0,0,8'h87,1, 1,8'h65,1,0,0);
      add(0,1,0,0,0,8'h5A,1, 1,8'h87,0,0,0);
      add(0,1,0,0,0,8'h5A,1, 0,8'h87,0,0,0);
      // fill FIFO, then push+pop while full across pointer wrap
      add(0,1,1,0,3,8'h5A,0, 0,8'h87,0,0,0);
      add(0,1,0,0,0,8'hF1,0, 0,8'h87,1,0,0);
      add(0,1,0,0,0,8'hE2,0, 1,8'hF1,1,0,0);
      add(0,1,0,0,0,8'hD3,0, 1,8'hF1,1,0,0);
      add(0,1,1,0,3,8'hC4,0, 1,8'hF1,1,0,0);
      add(0,1,0,0,0,8'hB5,1, 1,8'hF1,1,0,0);
      add(0,1,0,0,0,8'hA6,1, 1,8'hE2,1,0,0);
      add(0,1,0,0,0,8'h97,1, 1,8'hD3,1,0,0);
      add(0,1,0,0,0,8'h88,1, 1,8'hC4,1,0,0);
      add(0,1,0,0,0,8'h5A,1, 1,8'hB5,0,0,0);
      add(0,1,0,0,0,8'h5A,1, 1,8'hA6,0,0,0);
      add(0,1,0,0,0,8'h5A,1, 1,8'h97,0,0,0);
      add(0,1,0,0,0,8'h5A,1, 1,8'h88,0,0,0);
      add(0,1,0,0,0,8'h5A,1, 0,8'h88,0,0,0);
      // issue during WAIT is ignored, timing unchanged
      add(0,1,1,3,1,8'h5A,1, 0,8'h88,0,0,0);
      add(0,1,0,0,0,8'h5A,1, 0,8'h88,1,0,0);
      add(0,1,1,0,3,8'h5A,1, 0,8'h88,1,0,0);
      add(0,1,0,0,0,8'h5A,1, 0,8'h88,1,0,1);
      add(0,1,0,0,0,8'h31,1, 0,8'h88,1,0,1);
      add(0,1,0,0,0,8'h42,1, 1,8'h31,1,0,1);
      add(0,1,0,0,0,8'h5A,1, 1,8'h42,0,0,1);
      add(0,1,0,0,0,8'h5A,1, 0,8'h42,0,0,1);
      // overflow: ready low, back-to-back burst
      add(0,1,1,0,3,8'h5A,0, 0,8'h42,0,0,1);
      add(0,1,0,0,0,8'hA9,0, 0,8'h42,1,0,1);
      add(0,1,0,0,0,8'hCB,0, 1,8'hA9,1,0,1);
      add(0,1,0,0,0,8'hED,0, 1,8'hA9,1,0,1);
      add(0,1,1,0,3,8'h0F,0, 1,8'hA9,1,0,1);
      add(0,1,0,0,0,8'h11,0, 1,8'hA9,1,0,1);
      add(0,1,0,0,0,8'h22,0, 1,8'hA9,1,1,1);
      add(0,1,0,0,0,8'h33,0, 1,8'hA9,1,1,1);
      add(0,1,0,0,0,8'h44,0, 1,8'hA9,1,1,1);
      add(0,1,0,0,0,8'h5A,1, 1,8'hA9,0,1,1);
      add(0,1,0,0,0,8'h5A,1, 1,8'hCB,0,1,1);
      add(0,1,0,0,0,8'h5A,1, 1,8'hED,0,1,1);
      add(0,1,0,0,0,8'h5A,1, 1,8'h0F,0,1,1);
      add(0,1,0,0,0,8'h5A,1, 0,8'h0F,0,1,1);
      // reset in second capture cycle, then a clean burst
      add(0,1,1,3,3,8'h5A,1, 0,8'h0F,0,1,1);
      add(0,1,0,0,0,8'h5A,1, 0,8'h0F,1,1,1);
      add(0,1,0,0,0,8'h5A,1, 0,8'h0F,1,1,1);
      add(0,1,0,0,0,8'h5A,1, 0,8'h0F,1,1,1);
      add(0,1,0,0,0,8'h21,1, 0,8'h0F,1,1,1);
      add(1,1,0,0,0,8'h43,1, 1,8'h21,1,1,1);
      add(0,1,0,0,0,8'h5A,1, 0,8'h00,0,0,0);
      add(0,1,1,3,3,8'h5A,1, 0,8'h00,0,0,0);
      add(0,1,0,0,0,8'h5A,1, 0,8'h00,1,0,0);
      add(0,1,0,0,0,8'h5A,1, 0,8'h00,1,0,0);
      add(0,1,0,0,0,8'h5A,1, 0,8'h00,1,0,0);
      add(0,1,0,0,0,8'h21,1, 0,8'h00,1,0,0);
      add(0,1,0,0,0,8'h43,1, 1,8'h21,1,0,0);
      add(0,1,0,0,0,8'h65,1, 1,8'h43,1,0,0);
      add(0,1,0,0,0,8'h87,1, 1,8'h65,1,0,0);
      add(0,1,0,0,0,8'h5A,1, 1,8'h87,0,0,0);
      add(0,1,0,0,0,8'h5A,1, 0,8'h87,0,0,0);

      repeat (2) @(posedge clk);

      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         n_vec++;
         chk(i, "rx_valid",    8'(rx_valid),    8'(tv[i].ev));
         chk(i, "rx_data",     rx_data,         tv[i].ed);
         chk(i, "rx_busy",     8'(rx_busy),     8'(tv[i].eb));
         chk(i, "rx_overflow", 8'(rx_overflow), 8'(tv[i].eo));
         chk(i, "rd_cmd_err",  8'(rd_cmd_err),  8'(tv[i].ee));
         rst          = tv[i].rst;
         testmode_l   = tv[i].tm;
         rd_cmd_issue = tv[i].iss;
         rd_latency   = tv[i].lat;
         rd_burst     = tv[i].bur;
         pad_dq_rise  = tv[i].pd[3:0];
         pad_dq_fall  = tv[i].pd[7:4];
         rx_ready     = tv[i].rdy;
      end

      // latency boundaries: max latency, zero latency, testmode override
      probe(4'd15, 2'd0, 1'b1, 17);
      probe(4'd0,  2'd0, 1'b1, 2);
      probe(4'd1,  2'd3, 1'b1, 3);
      probe(4'd15, 2'd2, 1'b0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/dram_dq_rx_edgelogic.md
# dram_dq_rx_edgelogic

Read-data capture logic for one DRAM DQ pad slice, the receive-side counterpart of the pad clock/strobe drive logic. Opens a capture window a programmable number of cycles after a read command, pairs the rise/fall-edge pad samples into one word per core clock, and buffers the words in a 4-entry FIFO. The FIFO drains to the DRAM controller through a valid/ready handshake.

## Interface
- `WIDTH`, default 4: DQ bits per slice.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `testmode_l`  in  1  when low, the effective read latency is forced to 0.
- `rd_cmd_issue`  in  1  single-cycle pulse: a read command left the controller.
- `rd_latency`  in  4  cycles from issue to first beat, minus 1. Sampled with the issue pulse.
- `rd_burst`  in  2  number of capture cycles minus 1 (1..4 beats). Sampled with the issue pulse.
- `pad_dq_rise`  in  WIDTH  pad sample from the rising strobe edge, already retimed to `clk`.
- `pad_dq_fall`  in  WIDTH  pad sample from the falling strobe edge, already retimed to `clk`.
- `rx_data`  out  2*WIDTH  head FIFO entry, `{fall,rise}`.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts the head entry.
- `rx_busy`  out  1  state is not IDLE.
- `rx_overflow`  out  1  sticky: a beat was dropped.
- `rd_cmd_err`  out  1  sticky: an issue pulse was ignored.
- `scan_si`, `scan_se` in 1, `scan_so` out 1: scan chain. Functional only with `DRAM_RX_SCAN_EN`.

## Operation
- State machine: IDLE, WAIT, CAPTURE.
- Effective latency L = `testmode_l` ? `rd_latency` : 0. It is latched on the issue pulse together with burst count B = `rd_burst`.
- IDLE + issue:
  - L=0: go to CAPTURE.
  - L>0: go to WAIT with the down-counter loaded with L.
- WAIT: decrement the counter each cycle. At count 1, go to CAPTURE on the next edge.
- CAPTURE: push `{pad_dq_fall,pad_dq_rise}` every cycle for B+1 cycles.
- On the last CAPTURE cycle:
  - An issue pulse is accepted, giving back-to-back bursts. The next state is CAPTURE (L=0) or WAIT.
  - Otherwise the next state is IDLE.
- An issue pulse in WAIT, or in any CAPTURE cycle other than the last, is ignored and sets `rd_cmd_err`.
- FIFO: 4 entries, 2-bit read/write pointers plus a 3-bit count.
  - Pop when `rx_valid & rx_ready`.
  - Push when full and no pop: the beat is dropped, `rx_overflow` is set, and the pointers are unchanged.
  - Push and pop in the same cycle when full: both occur, and count stays 4.
  - Push and pop in the same cycle when empty: the push occurs, no pop (`rx_valid` was 0).
  - Pointers wrap modulo 4.
- `rx_data` is registered FIFO head data. When `rx_valid`=0 it holds the last value, or 0 after reset.
- Reset values: state IDLE, counter 0, FIFO empty, `rx_valid`=0, `rx_data`=0, `rx_busy`=0, `rx_overflow`=0, `rd_cmd_err`=0, `scan_so`=0.
- Reset during WAIT or CAPTURE aborts the burst. All FIFO contents are discarded.
- Sticky flags clear only on `rst`.

## Timing
- Issue at cycle T. Beats are captured at cycles T+L+1 … T+L+1+B.
- A beat captured at cycle C is visible on `rx_valid`/`rx_data` at C+1 when the FIFO was empty.
- `rx_busy` is high from T+1 through the last CAPTURE cycle.
- Throughput: one push per cycle and one pop per cycle, sustained.
- No combinational path from `rx_ready` to `rx_valid` or `rx_data`.

## Configuration
- `DRAM_RX_SCAN_EN` defined:
  - The latched L, latched B and the state register form one serial chain `scan_si` → `scan_so`.
  - When `scan_se`=1 the chain shifts one bit per clock. Functional updates of those registers are suspended; FIFO pushes are also suspended.
- `DRAM_RX_SCAN_EN` not defined:
  - `scan_so` is tied 0.
  - `scan_si` and `scan_se` are ignored.
  - No scan muxes are present.

## Test plan
- Single burst, `rd_latency`=3, `rd_burst`=3, `testmode_l`=1, `rx_ready`=1; rise/fall = 0x1/0x2, 0x3/0x4, …:
  - `rx_valid` high at T+5..T+8.
  - `rx_data` = 0x21, 0x43, 0x65, 0x87.
- Same burst with `testmode_l`=0: the first beat is captured at T+1 and `rx_valid` rises at T+2.
- `rx_ready`=0, `rd_burst`=3 followed by a back-to-back issue on the last capture cycle:
  - The FIFO fills after 4 beats and the next 4 beats are dropped.
  - `rx_overflow`=1; the first 4 entries drain intact afterwards.
- Issue pulse during WAIT: `rd_cmd_err`=1, and the original burst timing is unchanged.
- FIFO full, with `rx_ready`=1 during an active capture cycle: count stays 4, no overflow, and data order is preserved across pointer wrap.
- `rst` asserted in the second CAPTURE cycle:
  - Next cycle: IDLE, `rx_valid`=0, `rx_busy`=0, flags 0.
  - A subsequent issue behaves as the first scenario.
